// File: rtl/hash_req_arbiter.sv
// Round-robin arbiter merging NUM_REQ key/keylen FIFO pairs into one hash-engine read port.
// Optional macro HASH_ARB_PRIO0_EN: requester 0 wins whenever eligible, others round-robin.
module hash_req_arbiter #(
    parameter int unsigned  FIFOWIDTH = 128,
    parameter int unsigned  NUM_REQ   = 4,
    localparam int unsigned SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             iReqKeyEmpty,
    input  logic [NUM_REQ-1:0]             iReqKeyLenEmpty,
    output logic [NUM_REQ-1:0]             oReqKeyFifo_en,
    output logic [NUM_REQ-1:0]             oReqKeyLenFifo_en,
    input  logic [NUM_REQ*FIFOWIDTH-1:0]   iReqKey,
    input  logic [NUM_REQ*8-1:0]           iReqKeyLen,
    output logic                           oRdKeyEmpty,
    output logic                           oRdKeyLenEmpty,
    input  logic                           iRdKeyFifo_en,
    input  logic                           iRdKeyLenFifo_en,
    output logic [FIFOWIDTH-1:0]           oKey,
    output logic [7:0]                     oKeyLen,
    output logic                           oSrcIdWr,
    output logic [SRC_W-1:0]               oSrcId
);

    localparam int unsigned BEAT_W = 5;
    localparam int unsigned LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LEN    = 2'd2,
        STREAM = 2'd3
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic [SRC_W-1:0]   grant;
    logic [SRC_W-1:0]   grantNext;
    logic [SRC_W-1:0]   rrPtr;
    logic [SRC_W-1:0]   rrPtrNext;
    logic [SRC_W-1:0]   winner;
    logic [SRC_W-1:0]   ptrAfter;
    logic [BEAT_W-1:0]  remaining;
    logic [BEAT_W-1:0]  remainingNext;
    logic [BEAT_W-1:0]  beats;
    logic [NUM_REQ-1:0] rrMask;
    logic [LEN_W-1:0]   selLen;
    logic               anyElig;
    logic               winByPrio;
    logic               selLenEmpty;
    logic               selKeyEmpty;
    logic               lenAccept;
    logic               keyAccept;
    int unsigned        idx;

    assign selLenEmpty = iReqKeyLenEmpty[grant];
    assign selKeyEmpty = iReqKeyEmpty[grant];
    assign selLen      = iReqKeyLen[32'(grant)*LEN_W +: LEN_W];
    assign beats       = BEAT_W'((9'(selLen) + 9'd15) >> 4);
    assign lenAccept   = (state == GRANT) && iRdKeyLenFifo_en && !selLenEmpty;
    assign keyAccept   = (state == STREAM) && iRdKeyFifo_en && !selKeyEmpty && (remaining != '0);

    // Grant only moves on IDLE->GRANT, so the last read's data is still muxed from its source.
    assign oKey    = iReqKey[32'(grant)*FIFOWIDTH +: FIFOWIDTH];
    assign oKeyLen = selLen;
    assign oSrcId  = grant;

    // Round-robin search starting at rrPtr; optional fixed priority for requester 0.
    always_comb begin
        rrMask    = ~iReqKeyLenEmpty;
        winner    = '0;
        anyElig   = 1'b0;
        winByPrio = 1'b0;
        idx       = 0;
`ifdef HASH_ARB_PRIO0_EN
        if (!iReqKeyLenEmpty[0]) begin
            anyElig   = 1'b1;
            winByPrio = 1'b1;
        end
        rrMask[0] = 1'b0;
`endif
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rrPtr) + k) % NUM_REQ;
            if (!anyElig && rrMask[idx]) begin
                winner  = SRC_W'(idx);
                anyElig = 1'b1;
            end
        end
        ptrAfter = (32'(winner) == NUM_REQ - 1) ? '0 : winner + SRC_W'(1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant     <= '0;
            rrPtr     <= '0;
            remaining <= '0;
        end else begin
            state     <= stateNext;
            grant     <= grantNext;
            rrPtr     <= rrPtrNext;
            remaining <= remainingNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext     = state;
        grantNext     = grant;
        rrPtrNext     = rrPtr;
        remainingNext = remaining;
        case (state)
            IDLE: begin
                if (anyElig) begin
                    stateNext = GRANT;
                    grantNext = winner;
                    if (!winByPrio) begin
                        rrPtrNext = ptrAfter;
                    end
                end
            end
            GRANT: begin
                if (lenAccept) begin
                    stateNext = LEN;
                end
            end
            LEN: begin
                remainingNext = beats;
                stateNext     = (beats == '0) ? IDLE : STREAM;
            end
            STREAM: begin
                if (keyAccept) begin
                    remainingNext = remaining - BEAT_W'(1);
                    if (remaining == BEAT_W'(1)) begin
                        stateNext = IDLE;
                    end
                end else if (remaining == '0) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs: empties and upstream read enables steered to the granted requester only.
    always_comb begin
        oRdKeyLenEmpty    = 1'b1;
        oRdKeyEmpty       = 1'b1;
        oReqKeyLenFifo_en = '0;
        oReqKeyFifo_en    = '0;
        oSrcIdWr          = 1'b0;
        case (state)
            GRANT: begin
                oRdKeyLenEmpty = selLenEmpty;
                if (lenAccept) begin
                    oReqKeyLenFifo_en[grant] = 1'b1;
                    oSrcIdWr                 = 1'b1;
                end
            end
            STREAM: begin
                oRdKeyEmpty = selKeyEmpty || (remaining == '0);
                if (keyAccept) begin
                    oReqKeyFifo_en[grant] = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hash_req_arbiter.sv
// Bench for hash_req_arbiter: behavioural FIFOs, random engine, round-robin scoreboard.
module tb_hash_req_arbiter;

    localparam int unsigned FW = 128;
    localparam int unsigned NR = 4;
    localparam int unsigned SW = 2;

    logic                 clk;
    logic                 rst;
    logic [NR-1:0]        iReqKeyEmpty;
    logic [NR-1:0]        iReqKeyLenEmpty;
    logic [NR-1:0]        oReqKeyFifo_en;
    logic [NR-1:0]        oReqKeyLenFifo_en;
    logic [NR*FW-1:0]     iReqKey;
    logic [NR*8-1:0]      iReqKeyLen;
    logic                 oRdKeyEmpty;
    logic                 oRdKeyLenEmpty;
    logic                 iRdKeyFifo_en;
    logic                 iRdKeyLenFifo_en;
    logic [FW-1:0]        oKey;
    logic [7:0]           oKeyLen;
    logic                 oSrcIdWr;
    logic [SW-1:0]        oSrcId;

    hash_req_arbiter #(.FIFOWIDTH(FW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst),
        .iReqKeyEmpty(iReqKeyEmpty), .iReqKeyLenEmpty(iReqKeyLenEmpty),
        .oReqKeyFifo_en(oReqKeyFifo_en), .oReqKeyLenFifo_en(oReqKeyLenFifo_en),
        .iReqKey(iReqKey), .iReqKeyLen(iReqKeyLen),
        .oRdKeyEmpty(oRdKeyEmpty), .oRdKeyLenEmpty(oRdKeyLenEmpty),
        .iRdKeyFifo_en(iRdKeyFifo_en), .iRdKeyLenFifo_en(iRdKeyLenFifo_en),
        .oKey(oKey), .oKeyLen(oKeyLen), .oSrcIdWr(oSrcIdWr), .oSrcId(oSrcId)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester FIFO contents and their registered read data.
    logic [FW-1:0] keyQ [NR][$];
    logic [7:0]    lenQ [NR][$];
    logic [FW-1:0] keyOut [NR];
    logic [7:0]    lenOut [NR];
    int            stall [NR];
    bit            stallEn;
    bit            engOn;

    for (genvar g = 0; g < NR; g++) begin : gPack
        assign iReqKey[g*FW +: FW]  = keyOut[g];
        assign iReqKeyLen[g*8 +: 8] = lenOut[g];
    end

    // Reference model state: per-requester pending keys and expected grant stream.
    int            pendLen [NR][$];
    logic [FW-1:0] pendW [NR][$];
    int            expSrc [$];
    int            expLen [$];
    logic [FW-1:0] expW [$];
    int            mPtr;

    int errors = 0;
    int checks = 0;

    // Monitor state.
    bit busy, pendLenChk, pendWordChk;
    int curSrc, curLen, curN, kIssued, wChecked;

    task automatic chk(input bit ok, input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic addKey(input int src, input int len);
        int n;
        logic [FW-1:0] w;
        n = (len + 15) / 16;
        lenQ[src].push_back(8'(len));
        pendLen[src].push_back(len);
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            keyQ[src].push_back(w);
            pendW[src].push_back(w);
        end
    endtask

    // Turn the pending keys into the expected grant sequence.
    task automatic commitBatch();
        int w, len, n, c;
        bit any;
        forever begin
            any = 0;
            for (int i = 0; i < int'(NR); i++) if (pendLen[i].size() > 0) any = 1;
            if (!any) break;
            w = -1;
`ifdef HASH_ARB_PRIO0_EN
            if (pendLen[0].size() > 0) w = 0;
`endif
            if (w < 0) begin
                for (int k = 0; k < int'(NR); k++) begin
                    c = (mPtr + k) % NR;
`ifdef HASH_ARB_PRIO0_EN
                    if (c == 0) continue;
`endif
                    if (w < 0 && pendLen[c].size() > 0) w = c;
                end
                mPtr = (w + 1) % NR;
            end
            len = pendLen[w].pop_front();
            n = (len + 15) / 16;
            expSrc.push_back(w);
            expLen.push_back(len);
            for (int i = 0; i < n; i++) expW.push_back(pendW[w].pop_front());
        end
    endtask

    task automatic runBatch();
        bit done;
        commitBatch();
        engOn = 1;
        done = 0;
        for (int c = 0; c < 8000; c++) begin
            @(posedge clk);
            if (expSrc.size() == 0 && !busy) begin
                done = 1;
                break;
            end
        end
        chk(done, "batch drain timeout", FW'(expSrc.size()), '0);
        repeat (3) @(posedge clk);
        engOn = 0;
        for (int i = 0; i < int'(NR); i++)
            chk(keyQ[i].size() == 0 && lenQ[i].size() == 0, "leftover fifo data",
                FW'(keyQ[i].size() + lenQ[i].size()), '0);
    endtask

    // FIFO and hash-engine driver, updated just after each active edge.
    initial begin
        logic [NR-1:0] kEnS, lEnS;
        iReqKeyEmpty = '1;
        iReqKeyLenEmpty = '1;
        iRdKeyFifo_en = 0;
        iRdKeyLenFifo_en = 0;
        for (int i = 0; i < int'(NR); i++) begin
            keyOut[i] = '0;
            lenOut[i] = '0;
            stall[i] = 0;
        end
        forever begin
            @(negedge clk);
            kEnS = oReqKeyFifo_en;
            lEnS = oReqKeyLenFifo_en;
            @(posedge clk);
            #1;
            for (int i = 0; i < int'(NR); i++) begin
                if (kEnS[i] && keyQ[i].size() > 0) keyOut[i] = keyQ[i].pop_front();
                if (lEnS[i] && lenQ[i].size() > 0) lenOut[i] = lenQ[i].pop_front();
                if (stall[i] > 0) stall[i]--;
                else if (stallEn && keyQ[i].size() > 0 && $urandom_range(0, 47) == 0) stall[i] = 20;
                iReqKeyEmpty[i]    = (keyQ[i].size() == 0) || (stall[i] > 0);
                iReqKeyLenEmpty[i] = (lenQ[i].size() == 0);
            end
            iRdKeyLenFifo_en = engOn && ($urandom_range(0, 3) != 0);
            iRdKeyFifo_en    = engOn && ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor, sampling on the falling edge.
    initial begin
        bit lenAcc, keyAcc;
        logic [FW-1:0] w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = 0; pendLenChk = 0; pendWordChk = 0; kIssued = 0; wChecked = 0;
                continue;
            end
            if (pendLenChk) begin
                chk(oKeyLen == 8'(curLen), "keylen data", FW'(oKeyLen), FW'(curLen));
                pendLenChk = 0;
                if (curN == 0) busy = 0;
            end
            if (pendWordChk) begin
                w = (expW.size() > 0) ? expW.pop_front() : '0;
                chk(oKey == w, "key word", oKey, w);
                pendWordChk = 0;
                wChecked++;
                if (wChecked == curN) busy = 0;
            end
            lenAcc = iRdKeyLenFifo_en && !oRdKeyLenEmpty;
            keyAcc = iRdKeyFifo_en && !oRdKeyEmpty;
            if (lenAcc || oSrcIdWr) begin
                chk(oSrcIdWr == lenAcc, "srcIdWr strobe", FW'(oSrcIdWr), FW'(lenAcc));
                if (busy || expSrc.size() == 0) begin
                    chk(0, "unexpected grant", FW'(oSrcId), '0);
                end else begin
                    curSrc = expSrc.pop_front();
                    curLen = expLen.pop_front();
                    curN = (curLen + 15) / 16;
                    chk(oSrcId == SW'(curSrc), "srcId", FW'(oSrcId), FW'(curSrc));
                    chk(oReqKeyLenFifo_en == NR'(1 << curSrc), "keylen rd_en",
                        FW'(oReqKeyLenFifo_en), FW'(1 << curSrc));
                    busy = 1; pendLenChk = 1; kIssued = 0; wChecked = 0;
                end
            end else if (oReqKeyLenFifo_en != '0) begin
                chk(0, "stray keylen rd_en", FW'(oReqKeyLenFifo_en), '0);
            end
            if (keyAcc) begin
                if (!busy || pendLenChk || kIssued >= curN) begin
                    chk(0, "stray key read", FW'(oReqKeyFifo_en), '0);
                end else begin
                    chk(oReqKeyFifo_en == NR'(1 << curSrc), "key rd_en",
                        FW'(oReqKeyFifo_en), FW'(1 << curSrc));
                    kIssued++;
                    pendWordChk = 1;
                end
            end else if (oReqKeyFifo_en != '0) begin
                chk(0, "key rd_en without accept", FW'(oReqKeyFifo_en), '0);
            end
            if (busy && !pendLenChk && kIssued < curN && iReqKeyEmpty[curSrc])
                chk(oRdKeyEmpty == 1'b1, "stall empty", FW'(oRdKeyEmpty), FW'(1));
        end
    end

    task automatic chkResetOutputs(input string tag);
        chk(oReqKeyFifo_en == '0,    {tag, " key rd_en"},    FW'(oReqKeyFifo_en), '0);
        chk(oReqKeyLenFifo_en == '0, {tag, " keylen rd_en"}, FW'(oReqKeyLenFifo_en), '0);
        chk(oSrcIdWr == 1'b0,        {tag, " srcIdWr"},      FW'(oSrcIdWr), '0);
        chk(oSrcId == '0,            {tag, " srcId"},        FW'(oSrcId), '0);
        chk(oRdKeyEmpty == 1'b1,     {tag, " rdKeyEmpty"},   FW'(oRdKeyEmpty), FW'(1));
        chk(oRdKeyLenEmpty == 1'b1,  {tag, " rdKeyLenEmpty"}, FW'(oRdKeyLenEmpty), FW'(1));
    endtask

    initial begin
        int lens [5];
        bit hit;
        lens = '{0, 16, 40, 255, 0};
        rst = 0; engOn = 0; stallEn = 0; mPtr = 0;
        repeat (3) @(posedge clk);
        #1 chkResetOutputs("reset");
        #2 rst = 1;
        @(posedge clk);

        for (int i = 0; i < int'(NR); i++) addKey(i, 16);
        runBatch();
        addKey(1, 40);
        runBatch();
        addKey(2, 0);
        addKey(2, 255);
        runBatch();
        for (int k = 0; k < 4; k++) begin
            addKey(0, int'($urandom_range(1, 64)));
            addKey(3, int'($urandom_range(1, 64)));
        end
        runBatch();

        stallEn = 1;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < int'(NR); i++) begin
                for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                    lens[4] = int'($urandom_range(0, 255));
                    addKey(i, lens[$urandom_range(0, 4)]);
                end
            end
            runBatch();
        end
        stallEn = 0;
        repeat (25) @(posedge clk);

        // Asynchronous reset mid-key with five beats outstanding.
        addKey(2, 255);
        commitBatch();
        engOn = 1;
        hit = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            if (busy && kIssued == 11) begin
                hit = 1;
                break;
            end
        end
        chk(hit, "reach remaining=5 timeout", FW'(kIssued), FW'(11));
        #3 rst = 0;
        #1 chkResetOutputs("async reset");
        engOn = 0;
        for (int i = 0; i < int'(NR); i++) begin
            keyQ[i].delete(); lenQ[i].delete(); pendLen[i].delete(); pendW[i].delete();
            stall[i] = 0;
        end
        expSrc.delete(); expLen.delete(); expW.delete();
        mPtr = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1;
        @(posedge clk);
        for (int i = 0; i < int'(NR); i++) addKey(i, 16);
        runBatch();

        chk(expSrc.size() == 0 && expW.size() == 0, "expected queue drained",
            FW'(expSrc.size() + expW.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hash_req_arbiter.md
HASH_REQ_ARBITER -- requirements
Module: hash_req_arbiter

Interface
REQ-001 SHALL have parameter FIFOWIDTH, default 128, meaning width of one key word.
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning number of requester key/keylen FIFO pairs; SRC_W = clog2(NUM_REQ).
REQ-003 SHALL have one clock and an asynchronous active-low reset.
REQ-004 SHALL have ports, each listed as name, direction, width, meaning:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- iReqKeyEmpty  in  NUM_REQ  per-requester key FIFO empty.
- iReqKeyLenEmpty  in  NUM_REQ  per-requester keylen FIFO empty.
- oReqKeyFifo_en  out  NUM_REQ  per-requester key FIFO read enable.
- oReqKeyLenFifo_en  out  NUM_REQ  per-requester keylen FIFO read enable.
- iReqKey  in  NUM_REQ*FIFOWIDTH  packed key words; requester i occupies slice i.
- iReqKeyLen  in  NUM_REQ*8  packed key lengths in bytes.
- oRdKeyEmpty  out  1  merged key-FIFO empty seen by the hash engine.
- oRdKeyLenEmpty  out  1  merged keylen-FIFO empty seen by the hash engine.
- iRdKeyFifo_en  in  1  hash engine key read enable.
- iRdKeyLenFifo_en  in  1  hash engine keylen read enable.
- oKey  out  FIFOWIDTH  muxed key word.
- oKeyLen  out  8  muxed key length.
- oSrcIdWr  out  1  one-cycle strobe; a key has been granted to the hash engine.
- oSrcId  out  SRC_W  requester index that goes with oSrcIdWr.

Function
REQ-005 SHALL implement FSM states IDLE, GRANT, LEN, STREAM.
REQ-006 IDLE: a requester is eligible when iReqKeyLenEmpty[i]=0; with any requester eligible, SHALL load the grant register and go to GRANT on the next edge.
REQ-007 Arbitration SHALL be round-robin: search starts at last grant+1 and wraps from NUM_REQ-1 to 0.
REQ-008 GRANT: oRdKeyLenEmpty = iReqKeyLenEmpty[g]; an accepted keylen read (iRdKeyLenFifo_en & ~oRdKeyLenEmpty) SHALL drive oReqKeyLenFifo_en[g]=1 and oSrcIdWr=1 with oSrcId=g in that same cycle, then go to LEN.
REQ-009 LEN: SHALL capture beats = (iReqKeyLen[g]+15)>>4 (5-bit, range 0..16); beats=0 -> IDLE, otherwise -> STREAM.
REQ-010 STREAM: oRdKeyEmpty = iReqKeyEmpty[g] | (remaining==0); each accepted key read SHALL assert oReqKeyFifo_en[g] and decrement remaining; the read that takes remaining to 0 SHALL go to IDLE.
REQ-011 oKey/oKeyLen SHALL combinationally mux slice g of iReqKey/iReqKeyLen; g SHALL change only on IDLE->GRANT, so data of the last read (valid one cycle after rd_en) is still muxed from the correct source.
REQ-012 Outside GRANT, oRdKeyLenEmpty SHALL be 1; outside STREAM, oRdKeyEmpty SHALL be 1.
REQ-013 Hash-engine reads issued while the matching empty is 1 SHALL be ignored: no upstream rd_en and no state change.
REQ-014 No upstream rd_en SHALL ever assert for any requester other than g; at most one bit of each rd_en vector SHALL be high.
REQ-015 A requester with an empty key FIFO SHALL stall STREAM indefinitely; the grant SHALL NOT be revoked mid-key.

Reset
REQ-016 On rst=0 (asynchronous), the block SHALL enter IDLE with grant=0 and the round-robin pointer set so requester 0 is searched first.
REQ-017 During reset: all rd_en = 0, oSrcIdWr = 0, oSrcId = 0, oRdKeyEmpty = 1, oRdKeyLenEmpty = 1, remaining = 0.
REQ-018 A reset mid-key SHALL abandon the key; no recovery of partially read upstream data.

Configuration
REQ-019 Macro HASH_ARB_PRIO0_EN defined: requester 0 SHALL win whenever eligible in IDLE; the others SHALL be round-robin among themselves.
REQ-020 Macro HASH_ARB_PRIO0_EN undefined: pure round-robin over all requesters per REQ-007.

Verification
REQ-021 Single requester 1, keylen=40, 3 key words, engine always reading -> 1 keylen read and 3 key reads on requester 1 only; oSrcIdWr once with oSrcId=1; return to IDLE.
REQ-022 All 4 requesters hold one 16-byte key each, from reset -> grant order 0,1,2,3; each grant is exactly 1 keylen read + 1 key read.
REQ-023 keylen=0 on requester 2 -> keylen read with oSrcIdWr, zero key reads, IDLE after LEN; keylen=255 -> exactly 16 key reads.
REQ-024 Key FIFO of the granted requester empty for 20 cycles mid-key -> oRdKeyEmpty=1 throughout, no grant change, streaming resumes with the correct beat count.
REQ-025 Reset asserted during STREAM with remaining=5 -> all outputs at reset values immediately (asynchronous); after release, requester 0 searched first.
REQ-026 With HASH_ARB_PRIO0_EN and requesters 0 and 3 continuously eligible -> requester 0 granted every time; without the macro -> grants alternate 0,3,0,3.
